clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable synchronous clock divider that consumes the free-running system clock `clk` and produces a divided clock `clk_out` plus a one-cycle `tick` strobe at each divided-clock rising edge. It is the next stage after the clock source: it feeds slower clock domains and periodic enables. The divisor is loaded over a valid/ready handshake. A new divisor takes effect only at a period boundary, so no runt pulses or glitches appear on `clk_out`.

## Interface
- `CNT_W`, 16, width of divisor and period counter
- `clk` in 1, system clock; all flops on its rising edge except the optional negedge flop (see Configuration)
- `rst` in 1, synchronous, active-high reset
- `en` in 1, run request; low stops the output cleanly at the end of the current period
- `div_val` in CNT_W, requested divisor N, legal range 2..2^CNT_W-1
- `div_load` in 1, divisor valid
- `div_ready` out 1, divisor can be accepted
- `clk_out` out 1, divided clock (registered)
- `tick` out 1, one-cycle pulse, high in the cycle `clk_out` goes high
- `busy` out 1, high while in RUN or STOP
- `err` out 1, one-cycle pulse when an illegal divisor (0 or 1) is accepted

## Operation
- Internal registers:
  - `act_div`: active divisor
  - `pend_div` and `pend_vld`: one-entry reload buffer
  - `cnt`: runs 0..N-1
- Phase split: H = floor(N/2) and L = N-H. `clk_out` is high while `cnt` < H.
- Handshake:
  - `div_ready` = !`pend_vld`.
  - A transfer occurs when `div_load` && `div_ready`.
  - A legal value is written to `pend_div` and `pend_vld` is set.
  - An illegal value still completes the transfer, pulses `err` the next cycle, and is discarded.
- Period boundary: the cycle in which `cnt` == N-1, or any cycle in IDLE.
  - At a boundary with `pend_vld` set, `act_div` takes `pend_div` and `pend_vld` clears.
- FSM:
  - IDLE: `clk_out`=0 and `cnt`=0. Go to RUN when `en` is high and a divisor is available (`act_div` ≥ 2 or `pend_vld`). The pending value is applied on entry.
  - RUN: `cnt` increments and wraps at N-1. If `en` drops, go to STOP.
  - STOP: keep counting until `cnt` == N-1, then go to IDLE. `clk_out` ends low, so no truncated high phase.
  - STOP back to RUN: if `en` returns high before the boundary, return to RUN with no interruption.
- Simultaneous events:
  - A load in the same cycle as a boundary is buffered. The boundary uses the previously pending value if there is one, otherwise `act_div` is unchanged. The new value applies at the following boundary.
  - A second load while `pend_vld` is set is not accepted.
- A pending divisor survives STOP and IDLE and is applied on the next start.
- Reset: synchronous reset mid-period forces every register to its reset value at that edge. The period in progress is abandoned.

## Timing
- Reset values:
  - Outputs: `clk_out`=0, `tick`=0, `busy`=0, `err`=0, `div_ready`=1.
  - Internal: state IDLE, `cnt`=0, `act_div`=0, `pend_vld`=0.
- Start latency: a transfer at edge t with `en` high gives RUN at t+1 and `clk_out`/`tick` high at t+2.
- In RUN, `clk_out` rises every N cycles and `tick` rises coincident with it.
- Reload latency: `div_ready` returns high in the cycle after the boundary that consumes the pending value.
- `busy` falls in the cycle after the final boundary in STOP.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN`
  - Defined: for odd N, a falling-edge flop delays the high-phase end by half a `clk` period, giving an exact 50% duty. `tick` is unaffected. Even N is unchanged.
  - Undefined: rising-edge logic only. For odd N the high phase is floor(N/2) cycles and the low phase is ceil(N/2) cycles.

## Structure
- Package `clk_div_pkg`:
  - FSM state enum (`IDLE`, `RUN`, `STOP`).
  - `DIV_MIN`=2.
- One sub-module, `clk_div_reload`: the one-entry `pend_div` buffer with the valid/ready handshake and the legality check. The top holds the FSM, counter and output register.

## Test plan
- Reset, load N=4, `en`=1 → `clk_out` pattern 1100 repeating, `tick` every 4 cycles, first rise 2 cycles after transfer.
- Running at N=4, load N=6 mid-period → current period completes as 1100, then 111000; no runt.
- Load N=1 → `err` pulses once, `div_ready` high next cycle, output unchanged at N=4.
- Two back-to-back loads (6 then 8) → first accepted, `div_ready` low so second held until boundary, then 6 applies, then 8.
- `en` dropped at `cnt`=1 with N=8 → output finishes the period, `busy` falls after boundary, `clk_out`=0 held.
- N=5 without the macro → 11000; with the macro, high for 2.5 `clk` periods; `rst` asserted mid-period → all outputs at reset values next edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding,
// the minimum legal divisor and the divisor legality check.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   localparam logic [31:0] DIV_MIN = 32'd2;

   function automatic logic div_is_legal(input logic [31:0] val);
      return (val >= DIV_MIN);
   endfunction

endpackage

// File: rtl/clk_div_if.sv
// Divisor load handshake plus run control and divided-clock outputs.
interface clk_div_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             div_ready;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             err;

   modport master (
      output en, div_val, div_load,
      input  div_ready, clk_out, tick, busy, err
   );

   modport slave (
      input  en, div_val, div_load,
      output div_ready, clk_out, tick, busy, err
   );
endinterface

// File: rtl/clk_div_reload.sv
// One-entry divisor reload buffer: accepts a divisor when empty, rejects
// illegal values with a one-cycle err pulse, and empties on consume.
module clk_div_reload
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   input  logic             consume,
   output logic             div_ready,
   output logic [CNT_W-1:0] pend_div,
   output logic             pend_vld,
   output logic             err
);

   logic [CNT_W-1:0] pend_div_r;
   logic             pend_vld_r;
   logic             err_r;
   logic             xfer_s;
   logic             legal_s;

   assign xfer_s  = div_load && !pend_vld_r;
   assign legal_s = div_is_legal(32'(div_val));

   // Buffer write on a legal transfer, release when the top consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_div_r <= {CNT_W{1'b0}};
         pend_vld_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         err_r <= xfer_s && !legal_s;
         if (xfer_s && legal_s) begin
            pend_div_r <= div_val;
            pend_vld_r <= 1'b1;
         end else if (consume) begin
            pend_vld_r <= 1'b0;
         end
      end
   end

   assign div_ready = !pend_vld_r;
   assign pend_div  = pend_div_r;
   assign pend_vld  = pend_vld_r;
   assign err       = err_r;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider. Optional exact 50% duty for odd
// divisors is enabled with the CLK_DIV_ODD_DUTY50_EN macro.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic     clk,
   input  logic     rst,
   clk_div_if.slave bus
);

   localparam logic [1:0]       S_IDLE = 2'(IDLE);
   localparam logic [1:0]       S_RUN  = 2'(RUN);
   localparam logic [1:0]       S_STOP = 2'(STOP);
   localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] act_div_r;
   logic [CNT_W-1:0] last_s;
   logic [CNT_W-1:0] half_s;
   logic [CNT_W-1:0] pend_div_s;
   logic             pend_vld_s;
   logic             consume_s;
   logic             boundary_s;
   logic             go_s;
   logic             clk_out_r;
   logic             tick_r;
   logic             busy_r;

   clk_div_reload #(.CNT_W(CNT_W)) u_reload (
      .clk       (clk),
      .rst       (rst),
      .div_val   (bus.div_val),
      .div_load  (bus.div_load),
      .consume   (consume_s),
      .div_ready (bus.div_ready),
      .pend_div  (pend_div_s),
      .pend_vld  (pend_vld_s),
      .err       (bus.err)
   );

   assign last_s = act_div_r - ONE;
   assign half_s = act_div_r >> 1;

   // Next state and pending-divisor consumption at period boundaries.
   always_comb begin
      state_s    = state_r;
      consume_s  = 1'b0;
      boundary_s = (cnt_r == last_s);
      go_s       = bus.en && (div_is_legal(32'(act_div_r)) || pend_vld_s);
      case (state_r)
         S_IDLE: begin
            if (go_s) begin
               state_s   = S_RUN;
               consume_s = pend_vld_s;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN: begin
            consume_s = pend_vld_s && boundary_s;
            if (!bus.en) begin
               state_s = S_STOP;
            end else begin
               state_s = S_RUN;
            end
         end
         S_STOP: begin
            // A divisor that is still pending survives into IDLE.
            if (bus.en) begin
               state_s   = S_RUN;
               consume_s = pend_vld_s && boundary_s;
            end else if (boundary_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_STOP;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // FSM, period counter, active divisor and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         cnt_r     <= ZERO;
         act_div_r <= ZERO;
         clk_out_r <= 1'b0;
         tick_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         if (consume_s) begin
            act_div_r <= pend_div_s;
         end
         if ((state_r == S_IDLE) || (state_s == S_IDLE) || boundary_s) begin
            cnt_r <= ZERO;
         end else begin
            cnt_r <= cnt_r + ONE;
         end
         clk_out_r <= (state_r != S_IDLE) && (cnt_r < half_s);
         tick_r    <= (state_r != S_IDLE) && (cnt_r == ZERO);
         busy_r    <= (state_s != S_IDLE);
      end
   end

`ifdef CLK_DIV_ODD_DUTY50_EN
   logic odd_r;
   logic neg_r;

   // Remember whether the period that produced clk_out_r has an odd divisor.
   always_ff @(posedge clk) begin
      if (rst) begin
         odd_r <= 1'b0;
      end else begin
         odd_r <= act_div_r[0];
      end
   end

   // Half-cycle-late copy stretches the odd high phase by half a clk period.
   always_ff @(negedge clk) begin
      if (rst) begin
         neg_r <= 1'b0;
      end else begin
         neg_r <= clk_out_r && odd_r;
      end
   end

   assign bus.clk_out = clk_out_r || neg_r;
`else
   assign bus.clk_out = clk_out_r;
`endif

   assign bus.tick = tick_r;
   assign bus.busy = busy_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: scoreboard of expected clk_out/tick
// per cycle plus inline handshake, busy and err checks.
module tb_clk_div_prog;

   typedef struct packed {
      logic co;
      logic tk;
   } exp_t;

   logic      clk;
   logic      rst;
   int        checks;
   int        errors;
   exp_t      exp_q[$];

   clk_div_if #(.CNT_W(16)) bus ();

   clk_div_prog #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pat(input int hi, input int lo, input int reps);
      exp_t e;
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi + lo; i++) begin
            e.co = (i < hi);
            e.tk = (i == 0);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e.co = 1'b0;
      e.tk = 1'b0;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
      bus.div_val  = 16'd0;
      cyc();
      cyc();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Loads n with en high; returns just after the transfer edge.
   task automatic start(input logic [15:0] n);
      bus.div_val  = n;
      bus.div_load = 1'b1;
      bus.en       = 1'b1;
      cyc();
      bus.div_load = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.clk_out !== 1'b0)   begin errors++; $display("FAIL reset_clk_out got %b exp 0", bus.clk_out); end
      checks++; if (bus.tick !== 1'b0)      begin errors++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
      checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
      checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL reset_div_ready got %b exp 1", bus.div_ready); end
   endtask

   task automatic test_start_n4();
      exp_t e;
      do_reset();
      start(16'd4);
      push_idle(1);
      push_pat(2, 2, 3);
      for (int k = 1; k <= 13; k++) begin
         cyc();
         e = exp_q.pop_front();
         checks++;
         if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
            errors++;
            $display("FAIL start_n4 cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
         end
         if (k == 1) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", bus.busy); end
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b exp 1", bus.div_ready); end
         end
      end
   endtask

   task automatic test_reload();
      exp_t e;
      do_reset();
      start(16'd4);
      push_idle(1);
      push_pat(2, 2, 1);
      push_pat(3, 3, 2);
      for (int k = 1; k <= 17; k++) begin
         cyc();
         e = exp_q.pop_front();
         checks++;
         if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
            errors++;
            $display("FAIL reload cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
         end
         if (k == 2) begin
            bus.div_val  = 16'd6;
            bus.div_load = 1'b1;
         end
         if (k == 3) begin
            bus.div_load = 1'b0;
            checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL reload_ready_low got %b exp 0", bus.div_ready); end
         end
         if (k == 5) begin
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL reload_ready_back got %b exp 1", bus.div_ready); end
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      do_reset();
      start(16'd4);
      push_idle(1);
      push_pat(2, 2, 3);
      for (int k = 1; k <= 13; k++) begin
         cyc();
         e = exp_q.pop_front();
         checks++;
         if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
            errors++;
            $display("FAIL illegal cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
         end
         if (k == 2) begin
            bus.div_val  = 16'd1;
            bus.div_load = 1'b1;
         end
         if (k == 3) begin
            bus.div_load = 1'b0;
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", bus.err); end
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", bus.div_ready); end
         end
         if (k == 4) begin
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_single got %b exp 0", bus.err); end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      start(16'd4);
      push_idle(1);
      push_pat(2, 2, 1);
      push_pat(3, 3, 1);
      push_pat(4, 4, 2);
      for (int k = 1; k <= 27; k++) begin
         cyc();
         e = exp_q.pop_front();
         checks++;
         if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
            errors++;
            $display("FAIL b2b cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
         end
         if (k == 2) begin
            bus.div_val  = 16'd6;
            bus.div_load = 1'b1;
         end
         if (k == 3) begin
            bus.div_val = 16'd8;
         end
         if (k == 4) begin
            checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL b2b_held got %b exp 0", bus.div_ready); end
         end
         if (k == 5) begin
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_boundary got %b exp 1", bus.div_ready); end
         end
         if (k == 6) begin
            bus.div_load = 1'b0;
            checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken got %b exp 0", bus.div_ready); end
         end
         if (k == 11) begin
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_applied got %b exp 1", bus.div_ready); end
         end
      end
   endtask

   task automatic test_stop();
      exp_t e;
      do_reset();
      start(16'd8);
      push_idle(1);
      push_pat(4, 4, 1);
      push_idle(4);
      for (int k = 1; k <= 13; k++) begin
         cyc();
         e = exp_q.pop_front();
         checks++;
         if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
            errors++;
            $display("FAIL stop cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
         end
         if (k == 2) bus.en = 1'b0;
         if (k == 3 || k == 8) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stop_busy_high cyc %0d got %b exp 1", k, bus.busy); end
         end
         if (k == 9 || k == 12) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy_low cyc %0d got %b exp 0", k, bus.busy); end
         end
      end
   endtask

   task automatic test_odd_and_reset();
      exp_t e;
      do_reset();
      start(16'd5);
      push_idle(1);
`ifdef CLK_DIV_ODD_DUTY50_EN
      push_pat(3, 2, 2);
`else
      push_pat(2, 3, 2);
`endif
      for (int k = 1; k <= 13; k++) begin
         cyc();
         if (k <= 11) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.clk_out !== e.co || bus.tick !== e.tk) begin
               errors++;
               $display("FAIL odd5 cyc %0d clk_out/tick got %b%b exp %b%b", k, bus.clk_out, bus.tick, e.co, e.tk);
            end
         end
         if (k == 12) begin
            checks++; if (bus.clk_out !== 1'b1) begin errors++; $display("FAIL odd5_pre_reset got %b exp 1", bus.clk_out); end
            rst = 1'b1;
         end
         if (k == 13) begin
            rst = 1'b0;
            checks++; if (bus.clk_out !== 1'b0)   begin errors++; $display("FAIL midrst_clk_out got %b exp 0", bus.clk_out); end
            checks++; if (bus.tick !== 1'b0)      begin errors++; $display("FAIL midrst_tick got %b exp 0", bus.tick); end
            checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
            checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL midrst_err got %b exp 0", bus.err); end
            checks++; if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.div_ready); end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_start_n4();
      test_reload();
      test_illegal();
      test_back_to_back();
      test_stop();
      test_odd_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
